// File: rtl/quad_decoder_pkg.sv
// Shared encodings for the quadrature decoder: Gray pin states, FSM states and direction.
package quad_decoder_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Valid for single-bit transitions of {a,b}: up when the old A differs from the new B.
  function automatic logic quad_dir_up(input logic [1:0] prev, input logic [1:0] cur);
    return prev[1] ^ cur[0];
  endfunction

endpackage

// File: rtl/quad_decoder_filter.sv
// One encoder channel: 2-flop synchroniser followed by a FILT-sample stability filter.
module quad_filter #(
  parameter int FILT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_raw,
  output logic out_f
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt counts consecutive synced samples that disagree with the accepted level.
  always_comb begin
    sync1_d = in_raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_f = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder with filtered inputs, modulo up/down position counter and wrap pulse.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int N      = 8,
  parameter int MODULO = (1 << 8),
  parameter int FILT   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         a,
  input  logic         b,
  output logic [N-1:0] pos,
  output logic         dir,
  output logic         step,
  output logic         tc,
  output logic         err,
  output state_t       dbg_state
);

  localparam int IW = $clog2(FILT + 3);
  localparam logic [IW-1:0] INIT_LAST = IW'(FILT + 2);
  localparam logic [N-1:0]  POS_MAX   = N'(MODULO - 1);

  logic          a_f, b_f;
  logic [1:0]    cur, chg;
  state_t        state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]    prev_q, prev_d;
  logic [N-1:0]  pos_q, pos_d;
  logic          dir_q, dir_d;
  logic          step_q, step_d;
  logic          tc_q, tc_d;
  logic          err_q, err_d;

  quad_filter #(.FILT(FILT)) u_filt_a (.clk(clk), .rst(rst), .in_raw(a), .out_f(a_f));
  quad_filter #(.FILT(FILT)) u_filt_b (.clk(clk), .rst(rst), .in_raw(b), .out_f(b_f));

  assign cur = {a_f, b_f};
  assign chg = cur ^ prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= 2'b00;
      pos_q      <= '0;
      dir_q      <= DIR_DN;
      step_q     <= 1'b0;
      tc_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      tc_q       <= tc_d;
      err_q      <= err_d;
    end
  end

  // INIT lasts until the filters have settled on the pin levels present at reset release.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // prev follows cur every cycle, so on entry to RUN it already holds the settled level.
  always_comb begin
    prev_d = cur;
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    tc_d   = 1'b0;
    err_d  = err_q;
    if (clr) begin
      pos_d = '0;
      err_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (chg == 2'b11) begin
        err_d = 1'b1;
      end else if (chg != 2'b00 && en) begin
        step_d = 1'b1;
        if (quad_dir_up(prev_q, cur)) begin
          dir_d = DIR_UP;
          if (pos_q == POS_MAX) begin
            pos_d = '0;
            tc_d  = 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else begin
          dir_d = DIR_DN;
          if (pos_q == '0) begin
            pos_d = POS_MAX;
            tc_d  = 1'b1;
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
    end
  end

  assign pos       = pos_q;
  assign dir       = dir_q;
  assign step      = step_q;
  assign tc        = tc_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: cycle model of pin-to-count behaviour plus literal checkpoints.
module tb_quad_decoder;
  import quad_decoder_pkg::*;

  localparam int N      = 8;
  localparam int MODULO = 256;
  localparam int FILT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic clr = 1'b0;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic [N-1:0] pos;
  logic dir, step, tc, err;
  state_t dbg_state;

  int total = 0;
  int bad   = 0;
  int step_cnt = 0;
  int tc_cnt   = 0;
  int g = 0;

  always #5 clk = ~clk;

  quad_decoder #(.N(N), .MODULO(MODULO), .FILT(FILT)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .pos(pos), .dir(dir), .step(step), .tc(tc), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- model state ----------------
  int         m_pos  = 0;
  logic       m_dir  = 1'b0;
  logic       m_step = 1'b0;
  logic       m_tc   = 1'b0;
  logic       m_err  = 1'b0;
  logic       m_run  = 1'b0;
  int         m_init = 0;
  logic [1:0] m_prev = 2'b00;
  logic [1:0] ms1 = 2'b00, ms2 = 2'b00, mf = 2'b00, rv = 2'b00;
  int         rl[2] = '{0, 0};

  function automatic int gidx(input logic [1:0] q);
    case (q)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gcode(input int i);
    case (i % 4)
      0:       return QS_00;
      1:       return QS_01;
      2:       return QS_11;
      default: return QS_10;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one update per clock, evaluated from the values registered before the edge.
  initial begin
    int d;
    logic smp;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pos = 0; m_dir = 1'b0; m_step = 1'b0; m_tc = 1'b0; m_err = 1'b0;
        m_run = 1'b0; m_init = 0; m_prev = 2'b00;
        ms1 = 2'b00; ms2 = 2'b00; mf = 2'b00; rv = 2'b00; rl[0] = 0; rl[1] = 0;
      end else begin
        m_step = 1'b0;
        m_tc   = 1'b0;
        if (!m_run) begin
          if (m_init < FILT + 2) m_init++;
          else begin
            m_prev = mf;
            m_run  = 1'b1;
          end
          if (clr) begin m_pos = 0; m_err = 1'b0; end
        end else begin
          d = (gidx(mf) - gidx(m_prev) + 4) % 4;
          m_prev = mf;
          if (clr) begin
            m_pos = 0; m_err = 1'b0;
          end else if (d == 2) begin
            m_err = 1'b1;
          end else if (d != 0 && en) begin
            m_step = 1'b1;
            if (d == 1) begin
              m_dir = 1'b1;
              m_pos = (m_pos + 1) % MODULO;
              m_tc  = (m_pos == 0);
            end else begin
              m_dir = 1'b0;
              m_tc  = (m_pos == 0);
              m_pos = (m_pos + MODULO - 1) % MODULO;
            end
          end
        end
        for (int ch = 0; ch < 2; ch++) begin
          smp = ms2[ch];
          if (smp == rv[ch]) begin
            if (rl[ch] < FILT) rl[ch]++;
          end else begin
            rv[ch] = smp;
            rl[ch] = 1;
          end
          if (rl[ch] >= FILT) mf[ch] = rv[ch];
        end
        ms2 = ms1;
        ms1 = {a, b};
      end
    end
  end

  // Compare process: DUT against model every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("pos",  pos,  m_pos);
      check("dir",  dir,  m_dir);
      check("step", step, m_step);
      check("tc",   tc,   m_tc);
      check("err",  err,  m_err);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (step === 1'b1) step_cnt++;
      if (tc === 1'b1) tc_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_q(input int idx, input int hold);
    g = idx % 4;
    {a, b} = gcode(g);
    tick(hold);
  endtask

  task automatic up(input int hold);
    set_q(g + 1, hold);
  endtask

  task automatic down(input int hold);
    set_q(g + 3, hold);
  endtask

  initial begin
    int s0, t0;
    // 1: reset with pins at 11
    g = 2; {a, b} = gcode(g);
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("t1_pos", pos, 0);
    check("t1_err", err, 0);
    check("t1_steps", step_cnt, 0);
    check("t1_state", dbg_state, ST_RUN);

    // walk 11 -> 01 -> 00 with counting disabled
    down(8); down(8);
    check("t1_walk_pos", pos, 0);

    // 2: four up edges
    en = 1'b1;
    s0 = step_cnt;
    repeat (4) up(8);
    check("t2_pos", pos, 4);
    check("t2_dir", dir, 1);
    check("t2_steps", step_cnt - s0, 4);

    // 3: ramp to 255 then wrap both ways
    clr = 1'b1; tick(1); clr = 1'b0;
    check("t3_clr_pos", pos, 0);
    t0 = tc_cnt;
    repeat (255) up(4);
    tick(4);
    check("t3_ramp_pos", pos, 255);
    check("t3_ramp_tc", tc_cnt - t0, 0);
    up(8);
    check("t3_wrap_up_pos", pos, 0);
    check("t3_wrap_up_tc", tc_cnt - t0, 1);
    down(8);
    check("t3_wrap_dn_pos", pos, 255);
    check("t3_wrap_dn_tc", tc_cnt - t0, 2);
    check("t3_wrap_dn_dir", dir, 0);

    // 4: glitch rejection, illegal jump, clear
    s0 = step_cnt;
    a = ~a; tick(1); a = ~a; tick(10);
    check("t4_glitch_pos", pos, 255);
    check("t4_glitch_steps", step_cnt - s0, 0);
    check("t4_glitch_err", err, 0);
    repeat (5) up(8);
    check("t4_pre_jump_pos", pos, 4);
    set_q(2, 10);
    check("t4_jump_err", err, 1);
    check("t4_jump_pos", pos, 4);
    clr = 1'b1; tick(1); clr = 1'b0;
    check("t4_clr_err", err, 0);
    check("t4_clr_pos", pos, 0);

    // 5: en low while moving, then clr colliding with a step
    up(8); up(8);
    check("t5_pre_pos", pos, 2);
    en = 1'b0;
    s0 = step_cnt; t0 = tc_cnt;
    repeat (3) down(8);
    en = 1'b1;
    tick(20);
    check("t5_en_pos", pos, 2);
    check("t5_en_steps", step_cnt - s0, 0);
    check("t5_en_tc", tc_cnt - t0, 0);
    check("t5_en_dir", dir, 1);
    s0 = step_cnt;
    set_q(g + 1, 4);
    clr = 1'b1; tick(1); clr = 1'b0;
    tick(8);
    check("t5_clr_step_pos", pos, 0);
    check("t5_clr_step_steps", step_cnt - s0, 0);

    // 6: async reset mid-sequence, then INIT absorbs the pin level
    repeat (7) up(8);
    check("t6_pre_pos", pos, 7);
    set_q(g + 1, 2);
    rst = 1'b1;
    #1;
    check("t6_rst_pos", pos, 0);
    check("t6_rst_dir", dir, 0);
    check("t6_rst_step", step, 0);
    check("t6_rst_tc", tc, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_state", dbg_state, ST_INIT);
    tick(1);
    set_q(g + 1, 2);
    rst = 1'b0;
    s0 = step_cnt;
    tick(12);
    check("t6_init_steps", step_cnt - s0, 0);
    check("t6_init_err", err, 0);
    check("t6_init_pos", pos, 0);
    up(8);
    check("t6_post_pos", pos, 1);
    check("t6_post_steps", step_cnt - s0, 1);
    check("t6_post_dir", dir, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
